// File: rtl/i8088_bus_pkg.sv
// Shared 8088 local-bus definitions: bus-cycle state encoding, default widths and
// the read data returned when a cycle is aborted.
package i8088_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 8;
    localparam logic [7:0]  ABORT_DATA = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StT3,
        StTw,
        StT4
    } bus_state_e;

endpackage

// File: rtl/i8088_wait_timer.sv
// Counts TW cycles of a bus cycle; expired_o flags that the current TW cycle is
// the MAX_WAIT-th one, so a still-low READY must abort.
module i8088_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CntW'(MAX_WAIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the number of TW cycles already completed before this one.
    assign expired_o = en_i && (cnt_q >= CntW'(MAX_WAIT - 1));

endmodule

// File: rtl/i8088_bus_master.sv
// 8088 local-bus initiator: converts single-beat host requests into T1-T4 bus
// cycles with READY wait states and a wait-state timeout abort.
module i8088_bus_master
    import i8088_bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ALE,
    output logic              RD,
    output logic              WR,
    output logic              IOM,
    output logic [ADDR_W-1:0] ADDRESS,
    inout  wire  [DATA_W-1:0] DATA,
    input  logic              READY
);

    bus_state_e        state_q;
    logic              ale_q, rd_q, wr_q, iom_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              data_oe_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              expired;
    logic              accept;

    assign req_ready = RESET && ((state_q == StIdle) || (state_q == StT4));
    assign accept    = req_valid && req_ready;

    i8088_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .clear_i   (state_q == StT3),
        .en_i      (state_q == StTw),
        .expired_o (expired)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= StIdle;
            ale_q       <= 1'b0;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            iom_q       <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle, StT4: begin
                    data_oe_q <= 1'b0;
                    if (accept) begin
                        state_q <= StT1;
                        ale_q   <= 1'b1;
                        addr_q  <= req_addr;
                        iom_q   <= req_io;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StT1: begin
                    state_q   <= StT2;
                    ale_q     <= 1'b0;
                    rd_q      <= write_q;
                    wr_q      <= !write_q;
                    data_oe_q <= write_q;
                end
                StT2: begin
                    state_q <= StT3;
                end
                StT3, StTw: begin
                    if (READY) begin
                        state_q     <= StT4;
                        rd_q        <= 1'b1;
                        wr_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        if (!write_q) begin
                            rsp_rdata_q <= DATA;
                        end
                    end else if (expired) begin
                        state_q     <= StT4;
                        rd_q        <= 1'b1;
                        wr_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= DATA_W'(ABORT_DATA);
                    end else begin
                        state_q <= StTw;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ALE       = ale_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign IOM       = iom_q;
    assign ADDRESS   = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign DATA      = data_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_i8088_bus_master.sv
// Scoreboard bench for i8088_bus_master: a responder model drives READY/DATA and
// checks bus phases; a monitor compares each response against queued expectations.
module tb_i8088_bus_master;

    localparam int MAX_WAIT = 15;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid, req_write, req_io;
    logic        req_ready;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        ALE, RD, WR, IOM;
    logic [19:0] ADDRESS;
    wire  [7:0]  DATA;
    logic        READY;
    logic        resp_oe;
    logic [7:0]  resp_data;

    assign DATA = resp_oe ? resp_data : 8'hzz;

    i8088_bus_master #(
        .ADDR_W   (20),
        .DATA_W   (8),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_io    (req_io),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ALE       (ALE),
        .RD        (RD),
        .WR        (WR),
        .IOM       (IOM),
        .ADDRESS   (ADDRESS),
        .DATA      (DATA),
        .READY     (READY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        bit          write;
        bit          io;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          stall;
    } bus_t;

    typedef struct {
        bit         is_read;
        logic [7:0] rdata;
        bit         err;
        int         cyc;
    } rsp_t;

    bus_t bq[$];
    rsp_t sb[$];

    // Responder + bus-phase checker, sampling and driving at the falling edge.
    bus_t cur;
    int   rem = 0;
    int   ph  = 0;
    always @(negedge CLK) begin
        if (ALE) begin
            check("bus_queue_nonempty", 32'(bq.size() > 0), 1);
            if (bq.size() > 0) begin
                cur = bq.pop_front();
                rem = cur.stall;
            end
            ph = 1;
            check("t1_address", 32'(ADDRESS), 32'(cur.addr));
            check("t1_iom", 32'(IOM), 32'(cur.io));
            check("t1_strobes", 32'({RD, WR}), 32'h3);
        end else if (ph != 0) begin
            ph = ph + 1;
        end
        if (ph == 2) begin
            check("t2_rd", 32'(RD), 32'(cur.write));
            check("t2_wr", 32'(WR), 32'(!cur.write));
            if (cur.write) check("t2_data", 32'(DATA), 32'(cur.wdata));
        end
        if (ph >= 3 && (!RD || !WR)) begin
            check("tx_address", 32'(ADDRESS), 32'(cur.addr));
            check("tx_ale", 32'(ALE), 0);
            READY = (rem == 0);
            if (rem > 0) rem--;
        end else begin
            READY = 1'b1;
        end
        if (ph >= 3 && rsp_valid) begin
            check("t4_strobes", 32'({RD, WR}), 32'h3);
            check("t4_address", 32'(ADDRESS), 32'(cur.addr));
            if (cur.write) check("t4_data", 32'(DATA), 32'(cur.wdata));
        end
        resp_oe   = !RD;
        resp_data = cur.rdata;
        if (ph >= 3 && RD && WR) ph = 0;
    end

    // Response monitor.
    always @(negedge CLK) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.is_read) check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge just after the accept.
    task automatic issue(input bit wr, input bit io, input logic [19:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd, input int stall,
                         input bit expect_rsp, output int acc);
        int   t;
        bus_t b;
        rsp_t r;
        req_valid = 1'b1;
        req_write = wr;
        req_io    = io;
        req_addr  = addr;
        req_wdata = wd;
        t = 0;
        #1;
        while (!req_ready && t < 100) begin
            @(negedge CLK);
            #1;
            t++;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        b.write = wr; b.io = io; b.addr = addr; b.wdata = wd; b.rdata = rd; b.stall = stall;
        bq.push_back(b);
        if (expect_rsp) begin
            r.is_read = !wr;
            r.err     = (stall > MAX_WAIT);
            r.rdata   = (stall > MAX_WAIT) ? 8'hFF : rd;
            r.cyc     = acc + 4 + ((stall > MAX_WAIT) ? MAX_WAIT : stall);
            sb.push_back(r);
        end
        @(negedge CLK);
        req_valid = 1'b0;
        req_write = ~wr;
        req_io    = ~io;
        req_addr  = ~addr;
        req_wdata = ~wd;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        check("drain_timeout", 32'(sb.size()), 0);
        repeat (2) @(negedge CLK);
    endtask

    int a1, a2;
    initial begin
        RESET = 1'b0; READY = 1'b1; resp_oe = 1'b0; resp_data = 8'h00;
        req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0;
        cur.write = 0; cur.io = 0; cur.addr = 0; cur.wdata = 0; cur.rdata = 0; cur.stall = 0;
        repeat (3) @(negedge CLK);
        check("rst_ale", 32'(ALE), 0);
        check("rst_rd_wr", 32'({RD, WR}), 32'h3);
        check("rst_iom", 32'(IOM), 0);
        check("rst_address", 32'(ADDRESS), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        RESET = 1'b1;
        #1 check("idle_req_ready", 32'(req_ready), 1);
        @(negedge CLK);

        issue(1'b0, 1'b0, 20'h12345, 8'h00, 8'h5A, 0, 1'b1, a1);   // zero-wait memory read
        drain();
        issue(1'b1, 1'b1, 20'h003F8, 8'hC3, 8'h00, 0, 1'b1, a1);   // I/O write
        drain();
        issue(1'b0, 1'b0, 20'h0A000, 8'h00, 8'h3C, 3, 1'b1, a1);   // three wait states
        drain();
        issue(1'b0, 1'b0, 20'hF0001, 8'h00, 8'h99, 100, 1'b1, a1); // READY stuck low
        drain();

        issue(1'b1, 1'b0, 20'h00100, 8'h77, 8'h00, 0, 1'b1, a1);   // back-to-back pair
        issue(1'b0, 1'b0, 20'h00200, 8'h00, 8'h81, 0, 1'b1, a2);
        check("b2b_accept_gap", 32'(a2 - a1), 4);
        drain();

        issue(1'b1, 1'b0, 20'h0BEEF, 8'h42, 8'h00, 0, 1'b0, a1);   // reset mid-write
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("mid_rst_wr", 32'(WR), 1);
        check("mid_rst_rd", 32'(RD), 1);
        check("mid_rst_ale", 32'(ALE), 0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check("mid_rst_address", 32'(ADDRESS), 0);
        check("mid_rst_req_ready", 32'(req_ready), 0);
        RESET = 1'b1;
        repeat (6) @(negedge CLK);
        check("post_rst_no_rsp", 32'(sb.size()), 0);
        issue(1'b0, 1'b1, 20'h54321, 8'h00, 8'hE7, 1, 1'b1, a1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/i8088_bus_master.md
# i8088_bus_master

Initiator side of the 8088 local bus: turns single-beat read/write requests from an internal host port into 8088-style T1–T4 bus cycles driving ALE, RD, WR, IO/M, ADDRESS and DATA toward the memory/IO responders on the same bus. Supports READY-driven wait states and a wait-state timeout that aborts a hung cycle. It sits between the CPU-model/testbench traffic source and the shared 8088 pin bundle.

## Interface
Parameters:
- ADDR_W, 20, address width (1 MB space)
- DATA_W, 8, data bus width
- MAX_WAIT, 15, maximum TW cycles before abort (1..255)

Ports:
- CLK  in  1  bus clock; everything registered on rising edge
- RESET  in  1  synchronous, active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  request accepted on an edge where req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_io  in  1  1 = I/O space, 0 = memory
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse, cycle finished
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (reads)
- rsp_err  out  1  timeout abort, valid with rsp_valid
- ALE  out  1  address latch enable, active-high
- RD  out  1  read strobe, active-low
- WR  out  1  write strobe, active-low
- IOM  out  1  1 = I/O cycle, 0 = memory cycle
- ADDRESS  out  ADDR_W  bus address
- DATA  inout  DATA_W  tri-state data bus
- READY  in  1  responder ready; low inserts wait states

## Operation
- States: IDLE, T1, T2, T3, TW, T4.
- req_ready = 1 in IDLE and T4, else 0; forced 0 while RESET low.
- Accept in IDLE or T4 → T1; request fields latched into internal registers at accept.
- T1: ALE=1; ADDRESS, IOM driven from latched request. ADDRESS/IOM held stable T1 through T4.
- T2: ALE=0; read: RD=0; write: WR=0, DATA driven with latched wdata.
- T3: strobe held. READY=1 → T4; READY=0 → TW, wait counter cleared.
- TW: strobe held; counter increments each TW cycle. READY=1 → T4 (normal). Counter reaches MAX_WAIT with READY still 0 → T4 with abort flag.
- Read data captured from DATA on the edge leaving T3/TW with READY=1.
- T4: RD=WR=1; DATA released; rsp_valid=1 for exactly this cycle; rsp_err = abort flag; on abort rsp_rdata = 8'hFF. Next: T1 if new request accepted, else IDLE.
- DATA driven only in T2, T3, TW, T4 of a write; otherwise high-Z. Master never drives DATA during reads.
- req_* changes after acceptance have no effect on the cycle in flight.

## Timing
- Reset (RESET low at an edge): state IDLE, ALE=0, RD=1, WR=1, IOM=0, ADDRESS=0, DATA high-Z, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0. Applies mid-cycle too: strobes deassert at that edge, no rsp_valid for the aborted cycle.
- All bus outputs registered; change only at rising CLK.
- Zero-wait cycle: accept edge → T1 next cycle; rsp_valid in 4th cycle after accept (T1,T2,T3,T4).
- Each low-READY cycle sampled in T3/TW adds one TW cycle.
- Back-to-back: accept in T4 gives T4 → T1 with no IDLE gap; sustained throughput 1 transfer / 4 clocks.
- Abort: T1,T2,T3, MAX_WAIT TW cycles, T4 → rsp_valid at cycle 4+MAX_WAIT after accept.
- READY sampled only in T3/TW; ignored elsewhere.

## Structure
- Package i8088_bus_pkg: state enum typedef (IDLE,T1,T2,T3,TW,T4), ADDR_W/DATA_W defaults, ABORT_DATA = 8'hFF constant; shared with responder-side code.
- One sub-module: i8088_wait_timer (clear, enable, MAX_WAIT parameter, expired output, $clog2(MAX_WAIT+1)-bit counter).
- Main FSM, request latch, tri-state data driver in i8088_bus_master.

## Test plan
- Memory read, READY=1, responder returns 8'h5A at 20'h12345 → ALE high only T1, RD low T2–T3, IOM=0, rsp_valid in cycle 4 with rsp_rdata=8'h5A, rsp_err=0.
- I/O write 8'hC3 to 20'h003F8 → IOM=1, WR low T2–T3, DATA=8'hC3 T2–T4, high-Z in T1 and after T4.
- Read with READY low 3 cycles → exactly 3 TW cycles, RD held, rsp_valid at cycle 7, data captured on READY-high edge.
- READY held low, MAX_WAIT=15 → abort after 15 TW, rsp_valid at cycle 19, rsp_err=1, rsp_rdata=8'hFF, strobes released in T4.
- Two requests back-to-back (write then read) → second T1 immediately follows first T4, ADDRESS switches at T1 only.
- RESET low during T2 of a write → next edge WR=1, DATA high-Z, state IDLE, no rsp_valid; post-reset request completes normally.
